// File: rtl/mem_operand_fetch.sv
// Burst operand fetcher: reads len words from a combinational data memory into a small
// FIFO and streams them to the FP unit over valid/ready. Optional feature: FETCH_STRIDE_EN.
module mem_operand_fetch #(
  parameter int ADDR_W     = 5,
  parameter int LEN_W      = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
`ifdef FETCH_STRIDE_EN
  input  logic [ADDR_W-1:0] stride,
`endif
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              mem_read,
  output logic [31:0]       mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  output logic [31:0]       out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic [ADDR_W-1:0] w_step;
  logic [ADDR_W-1:0] w_addr;

  logic [31:0]       r_fifo_data [FIFO_DEPTH];
  logic              r_fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic [31:0]       r_out_hold;

  logic              w_accept;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_last_word;
  logic [31:0]       w_head_data;

  // Handshake: a word moves downstream on every rising edge where out_valid && out_ready;
  // out_valid never waits on out_ready and the head word is stable while out_valid && !out_ready.
  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_full      = (r_count == CNT_FULL);
  assign w_empty     = (r_count == '0);
  assign w_push      = (r_state == S_FETCH) && !w_full;
  assign w_pop       = !w_empty && out_ready;
  assign w_last_word = (r_remaining == LEN_W'(1));
  assign w_head_data = r_fifo_data[r_rd_ptr];

`ifdef FETCH_STRIDE_EN
  logic [ADDR_W-1:0] r_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step <= '0;
    end else if (w_accept) begin
      r_step <= stride;
    end
  end

  assign w_step = r_step;
`else
  assign w_step = ADDR_W'(1);
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (len == '0) ? S_FIN : S_FETCH;
      S_FETCH: if (w_push && w_last_word) w_state_nxt = S_DRAIN;
      // Leave DRAIN on the registered empty flag so FIN never overlaps a pop.
      S_DRAIN: if (w_empty) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_mem_addr  <= '0;
    end else if (w_accept) begin
      r_cur_addr  <= base_addr;
      r_remaining <= len;
    end else if (w_push) begin
      r_cur_addr  <= r_cur_addr + w_step;
      r_remaining <= r_remaining - LEN_W'(1);
      r_mem_addr  <= r_cur_addr;
    end
  end

  // Storage needs no reset: nothing reads an entry before it has been pushed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= mem_rdata;
      r_fifo_last[r_wr_ptr] <= w_last_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_out_hold <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + PTR_ONE;
        r_out_hold <= w_head_data;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_addr    = w_push ? r_cur_addr : r_mem_addr;
  assign mem_read  = w_push;
  assign mem_addr  = {{(32-ADDR_W){1'b0}}, w_addr};

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? r_out_hold : w_head_data;
  assign out_last  = !w_empty && r_fifo_last[r_rd_ptr];

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);
  assign dbg_state = r_state;

  a_no_read_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) mem_read |-> (r_count != CNT_FULL));

  a_count_bounded: assert property (
    @(posedge clk) disable iff (!rst_n) r_count <= CNT_FULL);

  a_idle_no_read: assert property (
    @(posedge clk) disable iff (!rst_n) !busy |-> !mem_read);

endmodule
